// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: ALU-control op codes,
// FSM state encoding and the divide-by-zero quotient fill value.
package muldiv_pkg;

    localparam logic [4:0] OP_MULT  = 5'b00110;
    localparam logic [4:0] OP_MULTU = 5'b00111;
    localparam logic [4:0] OP_DIV   = 5'b01000;
    localparam logic [4:0] OP_DIVU  = 5'b01001;
    localparam logic [4:0] OP_MTHI  = 5'b10010;
    localparam logic [4:0] OP_MTLO  = 5'b10011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_t;

    // Every quotient bit is forced to this value on divide by zero (LO = all ones).
    localparam logic DIV0_QUOT_FILL = 1'b1;

    function automatic logic is_signed_op(input logic [4:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit_divu_iter.sv
// One unsigned restoring-divide step: shift the next dividend bit into the
// partial remainder, conditionally subtract the divisor, emit one quotient bit.
module divu_iter #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quot_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quot_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem_in < divisor keeps diff below 2^WIDTH whenever the subtract succeeds,
    // so the top bit of diff is a clean borrow flag.
    always_comb begin
        shifted  = {rem_in, quot_in[WIDTH-1]};
        diff     = shifted - {1'b0, divisor};
        q_bit    = ~diff[WIDTH];
        rem_out  = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quot_out = {quot_in[WIDTH-2:0], q_bit};
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO unit: MULT/MULTU/DIV/DIVU/MTHI/MTLO with busy, done and cancel.
// Define MULDIV_FAST_MUL_EN to replace the shift-add loop with a native multiplier.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   acc_reg;    // product high half / partial remainder
    logic [WIDTH-1:0]   mq_reg;     // multiplier->product low half / dividend->quotient
    logic [WIDTH-1:0]   opb_reg;    // multiplicand magnitude / divisor magnitude
    logic [WIDTH-1:0]   a_raw_reg;
    logic               is_div_reg;
    logic               neg_res_reg;
    logic               neg_rem_reg;
    logic               div0_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic               busy_reg;
    logic               done_reg;

    logic               op_signed;
    logic               op_is_div;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_full;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   div_rem_next;
    logic [WIDTH-1:0]   div_quot_next;
    logic               div_q_bit;

    always_comb begin
        op_signed = is_signed_op(op);
        op_is_div = (op == OP_DIV) || (op == OP_DIVU);
        a_mag     = (op_signed && src_a[WIDTH-1]) ? -src_a : src_a;
        b_mag     = (op_signed && src_b[WIDTH-1]) ? -src_b : src_b;
        mul_sum   = {1'b0, acc_reg} + (mq_reg[0] ? {1'b0, opb_reg} : '0);
        mul_full  = {{WIDTH{1'b0}}, opb_reg} * {{WIDTH{1'b0}}, mq_reg};
        prod_fix  = neg_res_reg ? -{acc_reg, mq_reg} : {acc_reg, mq_reg};
        quot_fix  = neg_res_reg ? -mq_reg : mq_reg;
        rem_fix   = neg_rem_reg ? -acc_reg : acc_reg;
    end

    divu_iter #(.WIDTH(WIDTH)) u_divu_iter (
        .rem_in   (acc_reg),
        .quot_in  (mq_reg),
        .divisor  (opb_reg),
        .rem_out  (div_rem_next),
        .quot_out (div_quot_next),
        .q_bit    (div_q_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            mq_reg      <= '0;
            opb_reg     <= '0;
            a_raw_reg   <= '0;
            is_div_reg  <= 1'b0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            div0_reg    <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start && !cancel) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                acc_reg     <= '0;
                                mq_reg      <= op_is_div ? a_mag : b_mag;
                                opb_reg     <= op_is_div ? b_mag : a_mag;
                                a_raw_reg   <= src_a;
                                is_div_reg  <= op_is_div;
                                neg_res_reg <= op_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                                neg_rem_reg <= op_signed && src_a[WIDTH-1];
                                div0_reg    <= op_is_div && (src_b == '0);
                                // A fast multiply spends a single cycle in CALC.
                                cnt_reg     <= (FAST_MUL && !op_is_div) ? CNT_W'(WIDTH - 1) : '0;
                                state_reg   <= ST_CALC;
                                busy_reg    <= 1'b1;
                            end
                            OP_MTHI: hi_reg <= src_a;
                            OP_MTLO: lo_reg <= src_a;
                            default: ;
                        endcase
                    end
                end
                ST_CALC: begin
                    if (cancel) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        if (is_div_reg) begin
                            acc_reg <= div_rem_next;
                            mq_reg  <= div_quot_next;
                        end else if (FAST_MUL) begin
                            {acc_reg, mq_reg} <= mul_full;
                        end else begin
                            acc_reg <= mul_sum[WIDTH:1];
                            mq_reg  <= {mul_sum[0], mq_reg[WIDTH-1:1]};
                        end
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == CNT_W'(WIDTH - 1))
                            state_reg <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    if (!cancel) begin
                        done_reg <= 1'b1;
                        if (!is_div_reg) begin
                            {hi_reg, lo_reg} <= prod_fix;
                        end else if (div0_reg) begin
                            lo_reg <= {WIDTH{DIV0_QUOT_FILL}};
                            hi_reg <= a_raw_reg;
                        end else begin
                            lo_reg <= quot_fix;
                            hi_reg <= rem_fix;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // div_q_bit is folded into div_quot_next; kept visible for debug probes.
    logic unused_q_bit;
    assign unused_q_bit = div_q_bit;

    assign busy = busy_reg;
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule
